// File: rtl/four_div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results held until the next accepted start.
// Optional two's-complement operation when FOUR_DIV_SIGNED_EN is defined.
module four_div_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  // Stored partial remainder is always < D, so its top bit is provably zero
  // and only the low WIDTH bits are kept; the shifted A is full WIDTH+1.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_dz;

  logic             w_div0;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   w_a_sh, w_t;
  logic [WIDTH-1:0] w_q_sh, w_a_nxt, w_q_nxt;
  logic [WIDTH-1:0] w_quot_fin, w_rem_fin;
  logic             w_neg, w_last;

  assign w_div0 = (divisor == '0);

`ifdef FOUR_DIV_SIGNED_EN
  logic r_qneg, r_rneg;

  assign w_dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_quot_fin = r_qneg ? -w_q_nxt : w_q_nxt;
  assign w_rem_fin  = r_rneg ? -w_a_nxt : w_a_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (start && r_state != S_RUN && !w_div0) begin
      r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_rneg <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag  = dividend;
  assign w_dvs_mag  = divisor;
  assign w_quot_fin = w_q_nxt;
  assign w_rem_fin  = w_a_nxt;
`endif

  // Shift {A,Q} left, then trial-subtract D as A + ~{0,D} + 1.
  assign w_a_sh  = {r_a, r_q[WIDTH-1]};
  assign w_q_sh  = {r_q[WIDTH-2:0], 1'b0};
  assign w_t     = w_a_sh + {1'b1, ~r_d} + {{WIDTH{1'b0}}, 1'b1};
  assign w_neg   = w_t[WIDTH];
  assign w_a_nxt = w_neg ? w_a_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_nxt = {w_q_sh[WIDTH-1:1], ~w_neg};
  assign w_last  = (r_cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = w_div0 ? S_DONE : S_RUN;
        else       w_state_nxt = S_IDLE;
      end
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (w_div0) begin
              r_quot <= '1;
              r_rem  <= dividend;
              r_dz   <= 1'b1;
            end else begin
              r_q   <= w_dvd_mag;
              r_a   <= '0;
              r_d   <= w_dvs_mag;
              r_cnt <= CW'(WIDTH);
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_quot <= w_quot_fin;
            r_rem  <= w_rem_fin;
            r_dz   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quot     = r_quot;
  assign rem      = r_rem;
  assign div_zero = r_dz;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

endmodule
